// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, driver state encoding and illegal-opcode predicate shared by the ALU driver slice
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_ROL = 4'b1000;
    localparam logic [3:0] OP_ROR = 4'b1001;
    localparam logic [3:0] OP_INC = 4'b1010;
    localparam logic [3:0] OP_DEC = 4'b1011;
    localparam logic [3:0] OP_EQ  = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    // everything above the compare opcode is unassigned in the team ALU
    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_EQ;
    endfunction

endpackage

// File: rtl/alu_rsp_reg.sv
// alu_rsp_reg: formats the sampled ALU result and holds it until the response is taken
module alu_rsp_reg
    import alu_pkg::*;
#(
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [3:0]       ctrl,
    input  logic [7:0]       alu_out,
    input  logic             alu_carry,
    input  logic [TAG_W-1:0] tag,
    output logic [7:0]       rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag
);

    logic       err_d;
    logic [7:0] data_d;
    logic       carry_d;
    logic       zero_d;

    // illegal opcodes discard the ALU result; carry only means something for add/sub
    always_comb begin
        err_d   = is_illegal(ctrl);
        data_d  = err_d ? 8'h00 : ctrl == OP_EQ ? {7'b0, alu_out[0]} : alu_out;
        carry_d = !err_d && (ctrl == OP_ADD || ctrl == OP_SUB) && alu_carry;
        zero_d  = err_d || alu_out == 8'h00;
    end

    // load only on capture, so the slice holds for as long as the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_tag   <= '0;
        end else if (load) begin
            rsp_data  <= data_d;
            rsp_carry <= carry_d;
            rsp_zero  <= zero_d;
            rsp_err   <= err_d;
            rsp_tag   <= tag;
        end
    end

endmodule

// File: rtl/alu_driver.sv
// alu_driver: issues one command at a time to a combinational ALU and returns a tagged response
module alu_driver
    import alu_pkg::*;
#(
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_ctrl,
    input  logic [7:0]       cmd_x,
    input  logic [7:0]       cmd_y,
    input  logic             cmd_chain,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [3:0]       alu_ctrl,
    output logic [7:0]       alu_x,
    output logic [7:0]       alu_y,
    input  logic [7:0]       alu_out,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag
);

    state_t           state;
    state_t           state_n;
    logic [TAG_W-1:0] tag_q;
    logic [7:0]       chain_q;
    logic             load;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else state <= state_n;
    end

    // one cycle each to issue and settle, then hold the response until taken
    always_comb begin
        state_n = state == S_IDLE    ? (cmd_valid ? S_ISSUE : S_IDLE) :
                  state == S_ISSUE   ? S_CAPTURE :
                  state == S_CAPTURE ? S_RESP :
                  (rsp_ready ? S_IDLE : S_RESP);
    end

    // handshake and capture strobes decoded from state
    always_comb begin
        cmd_ready = state == S_IDLE;
        rsp_valid = state == S_RESP;
        load      = state == S_CAPTURE;
    end

    // register the ALU drive on accept; remember the last delivered result for chaining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ctrl <= '0;
            alu_x    <= '0;
            alu_y    <= '0;
            tag_q    <= '0;
            chain_q  <= '0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                alu_ctrl <= cmd_ctrl;
                alu_x    <= cmd_chain ? chain_q : cmd_x;
                alu_y    <= cmd_y;
                tag_q    <= cmd_tag;
            end
            if (rsp_valid && rsp_ready) chain_q <= rsp_data;
        end
    end

    alu_rsp_reg #(.TAG_W(TAG_W)) u_rsp (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .ctrl     (alu_ctrl),
        .alu_out  (alu_out),
        .alu_carry(alu_carry),
        .tag      (tag_q),
        .rsp_data (rsp_data),
        .rsp_carry(rsp_carry),
        .rsp_zero (rsp_zero),
        .rsp_err  (rsp_err),
        .rsp_tag  (rsp_tag)
    );

endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver: randomized and directed checks of alu_driver against a behavioural response model
module tb_alu_driver;
    import alu_pkg::*;

    localparam int TAG_W = 2;
    localparam int RW = 11 + TAG_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    logic [3:0] cmd_ctrl = '0;
    logic [7:0] cmd_x = '0;
    logic [7:0] cmd_y = '0;
    logic cmd_chain = 1'b0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic [3:0] alu_ctrl;
    logic [7:0] alu_x, alu_y, alu_out;
    logic alu_carry;
    logic rsp_valid;
    logic rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic rsp_carry, rsp_zero, rsp_err;
    logic [TAG_W-1:0] rsp_tag;
    logic [RW-1:0] rsp_vec;
    logic [8:0] alu_r;

    int n_tests = 0;
    int n_fail = 0;
    logic [7:0] chain_m = 8'h00;

    always #5 clk = ~clk;

    alu_driver #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ctrl(cmd_ctrl),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_chain(cmd_chain), .cmd_tag(cmd_tag),
        .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .rsp_err(rsp_err), .rsp_tag(rsp_tag)
    );

    // team ALU load; carry on non-arithmetic ops and illegal results are deliberately junk
    always_comb begin
        alu_r = {alu_x[0], 8'h5A};
        case (alu_ctrl)
            OP_ADD: alu_r = {1'b0, alu_x} + {1'b0, alu_y};
            OP_SUB: alu_r = {1'b0, alu_x} - {1'b0, alu_y};
            OP_AND: alu_r = {alu_x[0], alu_x & alu_y};
            OP_OR:  alu_r = {alu_x[0], alu_x | alu_y};
            OP_XOR: alu_r = {alu_x[0], alu_x ^ alu_y};
            OP_NOT: alu_r = {alu_x[0], ~alu_x};
            OP_SHL: alu_r = {alu_x[7], alu_x[6:0], 1'b0};
            OP_SHR: alu_r = {alu_x[0], 1'b0, alu_x[7:1]};
            OP_ROL: alu_r = {alu_x[7], alu_x[6:0], alu_x[7]};
            OP_ROR: alu_r = {alu_x[0], alu_x[0], alu_x[7:1]};
            OP_INC: alu_r = {1'b0, alu_x} + 9'd1;
            OP_DEC: alu_r = {1'b0, alu_x} - 9'd1;
            OP_EQ:  alu_r = {alu_x[0], 7'b0, alu_x == alu_y};
            default: ;
        endcase
    end
    assign {alu_carry, alu_out} = alu_r;
    assign rsp_vec = {rsp_data, rsp_carry, rsp_zero, rsp_err, rsp_tag};

    // expected response {data, carry, zero, err, tag} from integer arithmetic
    function automatic logic [RW-1:0] model(input logic [3:0] op, input logic [7:0] x,
                                            input logic [7:0] y, input logic [TAG_W-1:0] tag);
        int a, b, r;
        logic c;
        a = int'(x);
        b = int'(y);
        r = 0;
        c = 1'b0;
        if (op > 4'd12) return {8'h00, 1'b0, 1'b1, 1'b1, tag};
        case (op)
            4'd0: begin r = a + b; c = r > 255; end
            4'd1: begin r = a - b + 256; c = a < b; end
            4'd2: r = int'(x & y);
            4'd3: r = int'(x | y);
            4'd4: r = int'(x ^ y);
            4'd5: r = 255 - a;
            4'd6: r = a * 2;
            4'd7: r = a / 2;
            4'd8: r = (a * 2) % 256 + a / 128;
            4'd9: r = a / 2 + (a % 2) * 128;
            4'd10: r = a + 1;
            4'd11: r = a + 255;
            default: r = (a == b) ? 1 : 0;
        endcase
        r = r % 256;
        return {r[7:0], c, r == 0, 1'b0, tag};
    endfunction

    // one command through the handshake; reports the held response, latency and stability
    task automatic run_cmd(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                           input logic ch, input logic [TAG_W-1:0] tag, input int hold,
                           output logic [RW-1:0] r, output int lat, output bit stable);
        int w;
        w = 0;
        stable = 1'b1;
        lat = 0;
        r = '0;
        while (!cmd_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!cmd_ready) return;
        cmd_valid = 1'b1;
        cmd_ctrl = op;
        cmd_x = x;
        cmd_y = y;
        cmd_chain = ch;
        cmd_tag = tag;
        rsp_ready = (hold == 0);
        @(posedge clk); #1;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            if (cmd_ready) stable = 1'b0;
            cmd_ctrl = 4'($urandom);
            cmd_x = 8'($urandom);
            cmd_y = 8'($urandom);
            cmd_chain = 1'($urandom);
            cmd_tag = TAG_W'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        r = rsp_vec;
        if (cmd_ready) stable = 1'b0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (rsp_vec !== r || !rsp_valid || cmd_ready) stable = 1'b0;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        if (rsp_valid || !cmd_ready) stable = 1'b0;
    endtask

    task automatic test_reset();
        logic [RW+25:0] got;
        #12;
        got = {cmd_ready, rsp_valid, rsp_vec, alu_ctrl, alu_x, alu_y};
        n_tests++;
        if (got !== {1'b1, 1'b0, {(RW + 20){1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", got, {1'b1, 1'b0, {(RW + 20){1'b0}}});
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        logic [RW-1:0] r, e;
        int lat;
        bit st;
        e = model(OP_ADD, 8'h7F, 8'h01, 2'd1);
        run_cmd(OP_ADD, 8'h7F, 8'h01, 1'b0, 2'd1, 0, r, lat, st);
        n_tests++;
        if (r !== e || e !== {8'h80, 1'b0, 1'b0, 1'b0, 2'd1}) begin
            n_fail++;
            $display("FAIL add_7f_01: got %h expected %h", r, e);
        end
        n_tests++;
        if (lat !== 3 || !st) begin
            n_fail++;
            $display("FAIL add_latency: got %0d/%0d expected 3/1", lat, st);
        end
        chain_m = e[RW-1 -: 8];
    endtask

    task automatic test_chain();
        logic [RW-1:0] r, e;
        int lat;
        bit st;
        e = model(OP_SUB, 8'h05, 8'h05, 2'd3);
        run_cmd(OP_SUB, 8'h05, 8'h05, 1'b0, 2'd3, 0, r, lat, st);
        n_tests++;
        if (r !== e || r[RW-1 -: 8] !== 8'h00 || r[TAG_W+1] !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_zero: got %h expected %h", r, e);
        end
        chain_m = e[RW-1 -: 8];
        e = model(OP_ADD, chain_m, 8'h03, 2'd2);
        run_cmd(OP_ADD, 8'hAA, 8'h03, 1'b1, 2'd2, 0, r, lat, st);
        n_tests++;
        if (r !== e || r[RW-1 -: 8] !== 8'h03) begin
            n_fail++;
            $display("FAIL chain_add: got %h expected %h", r, e);
        end
        chain_m = e[RW-1 -: 8];
    endtask

    task automatic test_illegal();
        logic [RW-1:0] r;
        int lat;
        bit st;
        run_cmd(4'b1110, 8'h13, 8'h27, 1'b0, 2'd2, 0, r, lat, st);
        n_tests++;
        if (r !== {8'h00, 1'b0, 1'b1, 1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL illegal_op: got %h expected %h", r, {8'h00, 1'b0, 1'b1, 1'b1, 2'd2});
        end
        n_tests++;
        if (lat !== 3 || !st) begin
            n_fail++;
            $display("FAIL illegal_latency: got %0d/%0d expected 3/1", lat, st);
        end
        chain_m = 8'h00;
    endtask

    task automatic test_backpressure();
        logic [RW-1:0] r, e;
        int lat;
        bit st;
        e = model(OP_OR, 8'hF0, 8'h0F, 2'd2);
        run_cmd(OP_OR, 8'hF0, 8'h0F, 1'b0, 2'd2, 5, r, lat, st);
        n_tests++;
        if (r !== e || r[RW-1 -: 8] !== 8'hFF) begin
            n_fail++;
            $display("FAIL or_backpressure: got %h expected %h", r, e);
        end
        n_tests++;
        if (lat !== 3 || !st) begin
            n_fail++;
            $display("FAIL hold_stable: got %0d/%0d expected 3/1", lat, st);
        end
        chain_m = e[RW-1 -: 8];
    endtask

    task automatic test_compare();
        logic [RW-1:0] r;
        int lat;
        bit st;
        run_cmd(OP_EQ, 8'h3C, 8'h3C, 1'b0, 2'd0, 0, r, lat, st);
        n_tests++;
        if (r !== {8'h01, 1'b0, 1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL eq_equal: got %h expected %h", r, {8'h01, 1'b0, 1'b0, 1'b0, 2'd0});
        end
        run_cmd(OP_EQ, 8'h3C, 8'h3D, 1'b0, 2'd1, 0, r, lat, st);
        n_tests++;
        if (r !== {8'h00, 1'b0, 1'b1, 1'b0, 2'd1}) begin
            n_fail++;
            $display("FAIL eq_differ: got %h expected %h", r, {8'h00, 1'b0, 1'b1, 1'b0, 2'd1});
        end
        chain_m = 8'h00;
    endtask

    task automatic test_reset_mid();
        logic [RW+25:0] got;
        logic [RW-1:0] r;
        int lat;
        bit st, seen;
        cmd_valid = 1'b1;
        cmd_ctrl = OP_ADD;
        cmd_x = 8'h09;
        cmd_y = 8'h09;
        cmd_chain = 1'b0;
        cmd_tag = 2'd3;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        got = {cmd_ready, rsp_valid, rsp_vec, alu_ctrl, alu_x, alu_y};
        n_tests++;
        if (got !== {1'b1, 1'b0, {(RW + 20){1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h expected %h", got, {1'b1, 1'b0, {(RW + 20){1'b0}}});
        end
        #2 rst_n = 1'b1;
        chain_m = 8'h00;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_mid_no_rsp: got rsp_valid 1 expected 0");
        end
        run_cmd(OP_ADD, 8'hEE, 8'h05, 1'b1, 2'd1, 0, r, lat, st);
        n_tests++;
        if (r !== model(OP_ADD, chain_m, 8'h05, 2'd1) || lat !== 3) begin
            n_fail++;
            $display("FAIL reset_mid_next: got %h lat %0d expected %h lat 3", r, lat, model(OP_ADD, chain_m, 8'h05, 2'd1));
        end
        chain_m = 8'h05;
    endtask

    task automatic test_back_to_back();
        logic [11:0] rdy, vld;
        cmd_valid = 1'b1;
        cmd_ctrl = OP_ADD;
        cmd_x = 8'h01;
        cmd_y = 8'h02;
        cmd_chain = 1'b0;
        cmd_tag = 2'd0;
        rsp_ready = 1'b1;
        for (int i = 11; i >= 0; i--) begin
            @(posedge clk); #1;
            rdy[i] = cmd_ready;
            vld[i] = rsp_valid;
        end
        cmd_valid = 1'b0;
        n_tests++;
        if (rdy !== 12'b000100010001 || vld !== 12'b001000100010) begin
            n_fail++;
            $display("FAIL back_to_back: got rdy %b vld %b expected 000100010001 001000100010", rdy, vld);
        end
        chain_m = 8'h03;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [RW-1:0] r, e;
        logic [3:0] op;
        logic [7:0] x, y;
        logic ch;
        logic [TAG_W-1:0] tag;
        int lat;
        bit st;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom);
            x = 8'($urandom);
            y = 8'($urandom);
            ch = ($urandom_range(0, 3) == 0);
            tag = TAG_W'($urandom);
            e = model(op, ch ? chain_m : x, y, tag);
            run_cmd(op, x, y, ch, tag, $urandom_range(0, 2), r, lat, st);
            n_tests++;
            if (r !== e || lat !== 3 || !st) begin
                n_fail++;
                $display("FAIL random_%0d op %h: got %h lat %0d st %0d expected %h lat 3 st 1", i, op, r, lat, st, e);
            end
            chain_m = e[RW-1 -: 8];
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_chain();
        test_illegal();
        test_backpressure();
        test_compare();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
